// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter: rotating-priority pick in IDLE, grant held until
// done / request drop / hold limit, then a one-cycle GAP before re-arbitration.
module rr_arbiter_4 #(
   parameter int unsigned MAX_HOLD = 15,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t           state, state_nxt;
   logic [1:0]       ptr, ptr_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [3:0]       gnt_nxt;
   logic [1:0]       gnt_id_nxt;
   logic             gnt_valid_nxt;
   logic             timeout_nxt;

   logic [1:0]       win_id;
   logic             win_found;
   logic [1:0]       scan_idx;
   logic             hold_max;

   // Rotating-priority scan starting at ptr; 2-bit add wraps 3 -> 0.
   always_comb begin
      win_id    = '0;
      win_found = 1'b0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         scan_idx = ptr + 2'(k);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
   end

   assign hold_max = (hold_cnt == CNT_W'(MAX_HOLD - 1));

   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      hold_cnt_nxt  = hold_cnt;
      gnt_nxt       = gnt;
      gnt_id_nxt    = gnt_id;
      gnt_valid_nxt = gnt_valid;
      timeout_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nxt     = GRANT;
               gnt_nxt       = 4'b0001 << win_id;
               gnt_id_nxt    = win_id;
               gnt_valid_nxt = 1'b1;
               hold_cnt_nxt  = '0;
            end
         end
         GRANT: begin
            if (done || !req[gnt_id] || hold_max) begin
               state_nxt     = GAP;
               gnt_nxt       = '0;
               gnt_valid_nxt = 1'b0;
               ptr_nxt       = gnt_id + 2'd1;
               // Only a pure hold-limit release is reported as a timeout.
               timeout_nxt   = !done && req[gnt_id];
            end else begin
               hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         hold_cnt  <= hold_cnt_nxt;
         gnt       <= gnt_nxt;
         gnt_id    <= gnt_id_nxt;
         gnt_valid <= gnt_valid_nxt;
         timeout   <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios plus random traffic, every cycle
// compared against a phase/owner reference model.
module tb_rr_arbiter_4;

   localparam int unsigned MAX_HOLD = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   always #5 clk = ~clk;

   rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: who owns the resource, for how many cycles, and where the
   // rotation starts next.  phase 0 = no owner, 1 = owned, 2 = forced gap.
   int m_phase = 0;
   int m_id    = 0;
   int m_ptr   = 0;
   int m_held  = 0;
   bit m_to    = 0;

   task automatic model_step();
      bit rel;
      if (reset) begin
         m_phase = 0; m_id = 0; m_ptr = 0; m_held = 0; m_to = 0;
         return;
      end
      m_to = 0;
      case (m_phase)
         0: begin
            for (int k = 0; k < 4; k++) begin
               if (req[(m_ptr + k) % 4]) begin
                  m_id    = (m_ptr + k) % 4;
                  m_phase = 1;
                  m_held  = 1;
                  break;
               end
            end
         end
         1: begin
            rel = 0;
            if (done || !req[m_id]) rel = 1;
            else if (m_held == MAX_HOLD) begin rel = 1; m_to = 1; end
            else m_held++;
            if (rel) begin
               m_phase = 2;
               m_ptr   = (m_id + 1) % 4;
            end
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic cycle();
      logic [3:0] exp_gnt;
      @(posedge clk);
      model_step();
      #1;
      exp_gnt = (m_phase == 1) ? 4'(1 << m_id) : 4'b0000;
      check("gnt",       32'(gnt),       32'(exp_gnt));
      check("gnt_valid", 32'(gnt_valid), 32'(m_phase == 1));
      check("gnt_id",    32'(gnt_id),    32'(m_id));
      check("timeout",   32'(timeout),   32'(m_to));
      check("onehot0",   32'($onehot0(gnt)), 32'd1);
   endtask

   task automatic run(input logic [3:0] r, input logic d, input int n);
      req  = r;
      done = d;
      repeat (n) cycle();
   endtask

   initial begin
      logic [3:0] r;
      req = '0; done = 1'b0;

      reset = 1'b1; run(4'b0000, 1'b0, 2); reset = 1'b0;

      // single requester, released by done
      run(4'b0100, 1'b0, 3); run(4'b0100, 1'b1, 1); run(4'b0000, 1'b0, 3);

      // all requesting, done one cycle after each grant appears
      for (int i = 0; i < 5; i++) begin
         run(4'b1111, 1'b0, 3); run(4'b1111, 1'b1, 1);
      end
      run(4'b0000, 1'b0, 3);

      // wrap: ptr=1 with req=1001 must pick 3, then 0
      reset = 1'b1; run(4'b0000, 1'b0, 1); reset = 1'b0;
      run(4'b0001, 1'b0, 2); run(4'b0001, 1'b1, 1); run(4'b0000, 1'b0, 2);
      run(4'b1001, 1'b0, 3); run(4'b1001, 1'b1, 1); run(4'b1001, 1'b0, 4);
      run(4'b1001, 1'b1, 1); run(4'b0000, 1'b0, 3);

      // hold limit: 15 cycles then timeout, then re-grant after gap
      run(4'b0010, 1'b0, 40); run(4'b0000, 1'b0, 3);

      // request drop releases without timeout; other requests never pre-empt
      run(4'b0100, 1'b0, 4); run(4'b0101, 1'b0, 3); run(4'b0001, 1'b0, 5);
      run(4'b0000, 1'b0, 3);

      // reset mid-grant
      run(4'b0010, 1'b0, 6);
      reset = 1'b1; run(4'b0010, 1'b0, 1); reset = 1'b0;
      run(4'b1111, 1'b0, 4); run(4'b0000, 1'b0, 3);

      // random traffic: mostly sticky requests so long grants and timeouts occur
      r = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) r = 4'($urandom);
         reset = ($urandom_range(0, 299) == 0);
         run(r, ($urandom_range(0, 11) == 0), 1);
      end
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
